// File: rtl/gpu_sched_pkg.sv
// Shared types and default widths for the shader stage scheduler.
// Queue ids match the processor queue_number field.
package gpu_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_READ  = 3'd2,
        S_LOAD  = 3'd3,
        S_FETCH = 3'd4,
        S_WAIT  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        Q_T = 2'd0,
        Q_L = 2'd1,
        Q_P = 2'd2
    } qid_t;

    localparam int PC_W_D    = 16;
    localparam int SIZE_W_D  = 16;
    localparam int DATA_W_D  = 256;
    localparam int AGE_MAX_D = 8;

endpackage

// File: rtl/stage_scheduler_pick.sv
// Combinational queue picker: aged T > aged L > P > L > T.
// Age flags are tied low when aging is compiled out.
module sched_prio_pick
    import gpu_sched_pkg::*;
#(
    parameter int SIZE_W = SIZE_W_D
) (
    input  logic [SIZE_W-1:0] t_size,
    input  logic [SIZE_W-1:0] l_size,
    input  logic [SIZE_W-1:0] p_size,
    input  logic              t_aged,
    input  logic              l_aged,
    output logic              valid,
    output logic [1:0]        id
);

    logic t_go;
    logic l_go;
    logic p_go;

    assign t_go = (t_size != '0);
    assign l_go = (l_size != '0);
    assign p_go = (p_size != '0);

    // Priority select among the eligible (nonempty) queues
    always_comb begin
        valid = t_go | l_go | p_go;
        id    = Q_T;
        if (t_go && t_aged)
            id = Q_T;
        else if (l_go && l_aged)
            id = Q_L;
        else if (p_go)
            id = Q_P;
        else if (l_go)
            id = Q_L;
        else
            id = Q_T;
    end

endmodule

// File: rtl/stage_scheduler.sv
// Stage scheduler: picks P/L/T queue, dequeues, bulk-loads regs, releases core.
// Optional starvation aging is enabled by defining SCHED_AGING_EN.
module stage_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int PC_W    = PC_W_D,
    parameter int SIZE_W  = SIZE_W_D,
    parameter int DATA_W  = DATA_W_D
`ifdef SCHED_AGING_EN
    ,
    parameter int AGE_MAX = AGE_MAX_D
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_new_pc,
    input  logic [SIZE_W-1:0] t_size,
    input  logic [SIZE_W-1:0] l_size,
    input  logic [SIZE_W-1:0] p_size,
    input  logic [PC_W-1:0]   t_pc,
    input  logic [PC_W-1:0]   l_pc,
    input  logic [PC_W-1:0]   p_pc,
    input  logic [DATA_W-1:0] t_ret_regs,
    input  logic [DATA_W-1:0] l_ret_regs,
    input  logic [DATA_W-1:0] p_ret_regs,
    output logic              t_reading,
    output logic              l_reading,
    output logic              p_reading,
    output logic [PC_W-1:0]   new_pc,
    output logic [DATA_W-1:0] queue_regs,
    output logic              writing_regs,
    output logic              pc_found,
    output logic              busy
);

    state_t            state;
    state_t            next;
    logic              pick_valid;
    logic [1:0]        pick_id;
    logic [1:0]        sel_id;
    logic              eval;
    logic              grant;
    logic              t_aged;
    logic              l_aged;
    logic [PC_W-1:0]   pc_mux;
    logic [DATA_W-1:0] regs_mux;

    sched_prio_pick #(
        .SIZE_W (SIZE_W)
    ) u_pick (
        .t_size (t_size),
        .l_size (l_size),
        .p_size (p_size),
        .t_aged (t_aged),
        .l_aged (l_aged),
        .valid  (pick_valid),
        .id     (pick_id)
    );

    assign eval  = (state == S_SEL) || (state == S_WAIT);
    assign grant = eval && pick_valid;

    // Next-state logic; WAIT re-polls the queues until one is nonempty
    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:  if (req_new_pc) next = S_SEL;
            S_SEL,
            S_WAIT:  next = pick_valid ? S_READ : S_WAIT;
            S_READ:  next = S_LOAD;
            S_LOAD:  next = S_FETCH;
            S_FETCH: next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    // Source muxes: PC by fresh pick, register image by latched choice
    always_comb begin
        pc_mux   = t_pc;
        regs_mux = t_ret_regs;
        unique case (pick_id)
            Q_P:     pc_mux = p_pc;
            Q_L:     pc_mux = l_pc;
            default: pc_mux = t_pc;
        endcase
        unique case (sel_id)
            Q_P:     regs_mux = p_ret_regs;
            Q_L:     regs_mux = l_ret_regs;
            default: regs_mux = t_ret_regs;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next;
    end

    // Registered outputs; each strobe is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_id       <= Q_T;
            new_pc       <= '0;
            queue_regs   <= '0;
            t_reading    <= 1'b0;
            l_reading    <= 1'b0;
            p_reading    <= 1'b0;
            writing_regs <= 1'b0;
            pc_found     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            busy         <= (next != S_IDLE);
            t_reading    <= grant && (pick_id == Q_T);
            l_reading    <= grant && (pick_id == Q_L);
            p_reading    <= grant && (pick_id == Q_P);
            writing_regs <= (state == S_READ);
            pc_found     <= (state == S_FETCH);
            if (grant) begin
                sel_id <= pick_id;
                new_pc <= pc_mux;
            end
            if (state == S_READ)
                queue_regs <= regs_mux;
        end
    end

`ifdef SCHED_AGING_EN
    localparam int AGE_W = $clog2(AGE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_TOP = AGE_W'(AGE_MAX);

    logic [AGE_W-1:0] t_age;
    logic [AGE_W-1:0] l_age;

    assign t_aged = (t_age == AGE_TOP);
    assign l_aged = (l_age == AGE_TOP);

    // Age L/T on each lost grant; clear on win
    always_ff @(posedge clk) begin
        if (rst) begin
            t_age <= '0;
            l_age <= '0;
        end else if (grant) begin
            if (pick_id == Q_T)
                t_age <= '0;
            else if (t_size != '0 && !t_aged)
                t_age <= t_age + 1'b1;
            if (pick_id == Q_L)
                l_age <= '0;
            else if (l_size != '0 && !l_aged)
                l_age <= l_age + 1'b1;
        end
    end
`else
    assign t_aged = 1'b0;
    assign l_aged = 1'b0;
`endif

endmodule

// File: tb/tb_stage_scheduler.sv
// Scoreboard bench for stage_scheduler: randomized requests, queue-level model.
// Aging model is active when SCHED_AGING_EN is defined.
module tb_stage_scheduler;

    localparam int PC_W   = 16;
    localparam int SIZE_W = 16;
    localparam int DATA_W = 256;
    localparam int AGE    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_new_pc = 1'b0;
    logic [SIZE_W-1:0] t_size = '0;
    logic [SIZE_W-1:0] l_size = '0;
    logic [SIZE_W-1:0] p_size = '0;
    logic [PC_W-1:0]   t_pc = '0;
    logic [PC_W-1:0]   l_pc = '0;
    logic [PC_W-1:0]   p_pc = '0;
    logic [DATA_W-1:0] t_ret_regs = '0;
    logic [DATA_W-1:0] l_ret_regs = '0;
    logic [DATA_W-1:0] p_ret_regs = '0;
    logic              t_reading;
    logic              l_reading;
    logic              p_reading;
    logic [PC_W-1:0]   new_pc;
    logic [DATA_W-1:0] queue_regs;
    logic              writing_regs;
    logic              pc_found;
    logic              busy;

    stage_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .req_new_pc   (req_new_pc),
        .t_size       (t_size),
        .l_size       (l_size),
        .p_size       (p_size),
        .t_pc         (t_pc),
        .l_pc         (l_pc),
        .p_pc         (p_pc),
        .t_ret_regs   (t_ret_regs),
        .l_ret_regs   (l_ret_regs),
        .p_ret_regs   (p_ret_regs),
        .t_reading    (t_reading),
        .l_reading    (l_reading),
        .p_reading    (p_reading),
        .new_pc       (new_pc),
        .queue_regs   (queue_regs),
        .writing_regs (writing_regs),
        .pc_found     (pc_found),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              id;
        logic [PC_W-1:0] pc;
        logic [DATA_W-1:0] data;
        int              rc;
        bit              direct;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   strobe_cyc = 0;
    bit   mon_en = 1'b0;
    int   la = 0;
    int   ta = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference choice: queue ids T=0, L=1, P=2
    function int model_pick(input int ps, input int ls, input int ts);
        int w;
`ifdef SCHED_AGING_EN
        if (ts != 0 && ta == AGE)      w = 0;
        else if (ls != 0 && la == AGE) w = 1;
        else if (ps != 0)              w = 2;
        else if (ls != 0)              w = 1;
        else                           w = 0;
        if (w == 1) la = 0;
        else if (ls != 0 && la < AGE) la = la + 1;
        if (w == 0) ta = 0;
        else if (ts != 0 && ta < AGE) ta = ta + 1;
`else
        if (ps != 0)      w = 2;
        else if (ls != 0) w = 1;
        else              w = 0;
`endif
        return w;
    endfunction

    function bit outs_zero();
        return !t_reading && !l_reading && !p_reading && new_pc == '0 &&
               queue_regs == '0 && !writing_regs && !pc_found && !busy;
    endfunction

    // Monitor: pops the scoreboard on each dispatch
    always @(negedge clk) begin
        if (mon_en) begin
            if (t_reading || l_reading || p_reading) begin
                int got;
                got = p_reading ? 2 : (l_reading ? 1 : 0);
                checks++;
                strobe_cyc = cyc;
                if (int'(t_reading) + int'(l_reading) + int'(p_reading) != 1) begin
                    errors++;
                    $display("FAIL strobe_onehot got t%0b l%0b p%0b want one", t_reading, l_reading, p_reading);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected got queue %0d want none", got);
                end else if (got != sb[0].id) begin
                    errors++;
                    $display("FAIL strobe_queue got %0d want %0d", got, sb[0].id);
                end
            end
            if (writing_regs) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected got write want none");
                end else if (queue_regs !== sb[0].data || cyc != strobe_cyc + 1) begin
                    errors++;
                    $display("FAIL queue_regs got %h at +%0d want %h at +1", queue_regs, cyc - strobe_cyc, sb[0].data);
                end
            end
            if (pc_found) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL found_unexpected got pc_found want none");
                end else begin
                    if (new_pc !== sb[0].pc || cyc != strobe_cyc + 3 || busy) begin
                        errors++;
                        $display("FAIL pc_found got pc %h at +%0d busy %0b want pc %h at +3 busy 0", new_pc, cyc - strobe_cyc, busy, sb[0].pc);
                    end
                    if (sb[0].direct && cyc != sb[0].rc + 5) begin
                        errors++;
                        $display("FAIL latency got %0d want 5", cyc - sb[0].rc);
                    end
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic rand_inputs();
        t_pc = PC_W'($urandom);
        l_pc = PC_W'($urandom);
        p_pc = PC_W'($urandom);
        for (int i = 0; i < DATA_W / 32; i++) begin
            t_ret_regs[i*32 +: 32] = $urandom;
            l_ret_regs[i*32 +: 32] = $urandom;
            p_ret_regs[i*32 +: 32] = $urandom;
        end
    endtask

    task automatic set_sizes(input int ps, input int ls, input int ts);
        p_size = SIZE_W'(ps);
        l_size = SIZE_W'(ls);
        t_size = SIZE_W'(ts);
    endtask

    // One request; late>0 keeps all queues empty for that many cycles first
    task automatic txn(input int ps, input int ls, input int ts, input int late);
        exp_t e;
        int   n;
        rand_inputs();
        e.id     = model_pick(ps, ls, ts);
        e.pc     = (e.id == 2) ? p_pc : ((e.id == 1) ? l_pc : t_pc);
        e.data   = (e.id == 2) ? p_ret_regs : ((e.id == 1) ? l_ret_regs : t_ret_regs);
        e.rc     = cyc;
        e.direct = (late == 0);
        sb.push_back(e);
        if (late == 0) set_sizes(ps, ls, ts);
        else           set_sizes(0, 0, 0);
        req_new_pc = 1'b1;
        @(negedge clk);
        req_new_pc = 1'b0;
        if (late > 0) begin
            repeat (late) begin
                req_new_pc = busy && ($urandom_range(0, 1) == 1);
                @(negedge clk);
            end
            checks++;
            if (t_reading || l_reading || p_reading || !busy) begin
                errors++;
                $display("FAIL wait_state got busy %0b strobes %0b%0b%0b want busy 1 no strobe", busy, p_reading, l_reading, t_reading);
            end
            set_sizes(ps, ls, ts);
        end
        n = 0;
        while (!pc_found && n < 40) begin
            req_new_pc = busy && ($urandom_range(0, 1) == 1);
            if (t_reading || l_reading || p_reading)
                set_sizes($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
            @(negedge clk);
            n++;
        end
        req_new_pc = 1'b0;
        if (n >= 40) begin
            errors++;
            $display("FAIL timeout got no pc_found want pc_found within 40 cycles");
        end
    endtask

    initial begin
        int n;
        int ps, ls, ts, late;
        repeat (3) @(negedge clk);
        checks++;
        if (!outs_zero()) begin
            errors++;
            $display("FAIL reset_outputs got nonzero outputs want all 0");
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy || t_reading || l_reading || p_reading || pc_found) begin
                errors++;
                $display("FAIL idle_hold got busy %0b want 0", busy);
            end
        end

        set_sizes(1, 0, 0);
        rand_inputs();
        req_new_pc = 1'b1;
        @(negedge clk);
        req_new_pc = 1'b0;
        n = 0;
        while (!writing_regs && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL load_reach got no writing_regs want writing_regs");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!outs_zero()) begin
            errors++;
            $display("FAIL reset_in_load got busy %0b pc %h want all 0", busy, new_pc);
        end
        rst = 1'b0;
        set_sizes(0, 0, 0);
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        txn(2, 1, 0, 0);
        txn(0, 0, 1, 8);
        txn(0, 3, 4, 0);
        txn(0, 0, 7, 0);
        txn(1, 1, 1, 3);
        repeat (10) txn(5, 0, 5, 0);
        for (int k = 0; k < 40; k++) begin
            ps = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 9);
            ls = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 9);
            ts = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 9);
            late = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            if (ps == 0 && ls == 0 && ts == 0) ts = 1;
            txn(ps, ls, ts, late);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
